// File: rtl/matmul_sequencer_pkg.sv
// Shared constants, state encoding and width helper for the matmul sequencer.
package matmul_sequencer_pkg;

    localparam int DEF_ADDR_BITS = 4;
    localparam int MAT_N         = 4;
    localparam int DRAIN_CYCLES  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Start/done handshake plus memory address and MAC control bundle.
interface matmul_sequencer_if #(
    parameter int ADDR_BITS = matmul_sequencer_pkg::DEF_ADDR_BITS
);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [ADDR_BITS-1:0] Dir_M1;
    logic [ADDR_BITS-1:0] Dir_M2;
    logic                 mac_en;
    logic                 mac_first;
    logic                 res_we;
    logic [ADDR_BITS-1:0] Dir_R;

    modport slave (
        input  start,
        output busy, done, Dir_M1, Dir_M2, mac_en, mac_first, res_we, Dir_R
    );

    modport master (
        output start,
        input  busy, done, Dir_M1, Dir_M2, mac_en, mac_first, res_we, Dir_R
    );
endinterface

// File: rtl/mm_index_counter.sv
// Nested i/j/k index counter, k innermost; all indices wrap N-1 -> 0 with carry.
module mm_index_counter
    import matmul_sequencer_pkg::*;
#(
    parameter int N = MAT_N,
    localparam int CW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] i,
    output logic [CW-1:0] j,
    output logic [CW-1:0] k,
    output logic          k_first,
    output logic          k_last,
    output logic          last
);
    localparam logic [CW-1:0] MAX = CW'(N - 1);

    assign k_first = (k == '0);
    assign k_last  = (k == MAX);
    assign last    = k_last && (j == MAX) && (i == MAX);

    // advance k each enabled cycle, carrying into j then i; the last triple wraps to 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (en) begin
            if (k_last) begin
                k <= '0;
                if (j == MAX) begin
                    j <= '0;
                    i <= (i == MAX) ? '0 : i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end else begin
                k <= k + 1'b1;
            end
        end
    end
endmodule

// File: rtl/matmul_sequencer.sv
// Sequences one N x N matrix multiply: operand addresses, MAC controls, result writes.
//
//  state    | meaning
//  ---------+--------------------------------------------------------
//  ST_IDLE  | waiting for start, all outputs quiet
//  ST_RUN   | one (i,j,k) operand address pair per cycle, N^3 cycles
//  ST_DRAIN | two cycles letting the MAC and write pipe empty
//  ST_DONE  | one-cycle done pulse, then back to idle
module matmul_sequencer
    import matmul_sequencer_pkg::*;
#(
    parameter int N         = MAT_N,
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input logic               clk,
    input logic               rst,
    matmul_sequencer_if.slave bus
);
    localparam int                   CW  = idx_width(N);
    localparam logic [ADDR_BITS-1:0] N_A = ADDR_BITS'(N);

    state_t               state_q, state_d;
    logic [1:0]           drain_cnt;
    logic                 run;
    logic [CW-1:0]        i, j, k;
    logic                 k_first, k_last, last;
    logic [ADDR_BITS-1:0] addr_m1, addr_m2, addr_r;
    logic                 en_d1, first_d1, we_d1, we_d2;
    logic [ADDR_BITS-1:0] r_d1, r_d2;

    assign run = (state_q == ST_RUN);

    mm_index_counter #(.N(N)) u_idx (
        .clk     (clk),
        .rst     (rst),
        .en      (run),
        .i       (i),
        .j       (j),
        .k       (k),
        .k_first (k_first),
        .k_last  (k_last),
        .last    (last)
    );

    assign addr_m1 = ADDR_BITS'(i) * N_A + ADDR_BITS'(k);
    assign addr_m2 = ADDR_BITS'(k) * N_A + ADDR_BITS'(j);
    assign addr_r  = ADDR_BITS'(i) * N_A + ADDR_BITS'(j);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // drain timer: loaded on the final RUN edge, counts down to terminal count 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                drain_cnt <= '0;
        else if (run && last)    drain_cnt <= 2'(DRAIN_CYCLES - 1);
        else if (drain_cnt != 0) drain_cnt <= drain_cnt - 1'b1;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start)       state_d = ST_RUN;
            ST_RUN:   if (last)            state_d = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == '0) state_d = ST_DONE;
            ST_DONE:                       state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // two-stage delay pipe matching the 1-cycle memory read and the MAC update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_d1    <= 1'b0;
            first_d1 <= 1'b0;
            we_d1    <= 1'b0;
            we_d2    <= 1'b0;
            r_d1     <= '0;
            r_d2     <= '0;
        end else begin
            en_d1    <= run;
            first_d1 <= run && k_first;
            we_d1    <= run && k_last;
            we_d2    <= we_d1;
            r_d1     <= run ? addr_r : '0;
            r_d2     <= r_d1;
        end
    end

    assign bus.busy      = run || (state_q == ST_DRAIN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.Dir_M1    = run ? addr_m1 : '0;
    assign bus.Dir_M2    = run ? addr_m2 : '0;
    assign bus.mac_en    = en_d1;
    assign bus.mac_first = first_d1;
    assign bus.res_we    = we_d2;
    assign bus.Dir_R     = r_d2;
endmodule

// File: tb/tb_matmul_sequencer.sv
// Randomized self-checking bench for matmul_sequencer at N = 2 and N = 4.
module tb_matmul_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    matmul_sequencer_if #(.ADDR_BITS(4)) bus2 ();
    matmul_sequencer_if #(.ADDR_BITS(4)) bus4 ();

    matmul_sequencer #(.N(2), .ADDR_BITS(4)) u_n2 (.clk(clk), .rst(rst), .bus(bus2));
    matmul_sequencer #(.N(4), .ADDR_BITS(4)) u_n4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [3:0] m1;
        logic [3:0] m2;
        logic       mac_en;
        logic       mac_first;
        logic       res_we;
        logic [3:0] dr;
    } obs_t;

    // expected outputs in cycle t after start is sampled (t <= 0 or past the run: idle)
    function automatic obs_t model(input int n, input int t);
        obs_t e;
        int   n3;
        int   idx;
        e  = '0;
        n3 = n * n * n;
        if (t >= 1 && t <= n3) begin
            idx  = t - 1;
            e.m1 = 4'((idx / (n * n)) * n + (idx % n));
            e.m2 = 4'((idx % n) * n + ((idx / n) % n));
        end
        e.busy      = (t >= 1) && (t <= n3 + 2);
        e.done      = (t == n3 + 3);
        e.mac_en    = (t >= 2) && (t <= n3 + 1);
        e.mac_first = e.mac_en && (((t - 2) % n) == 0);
        e.res_we    = (t >= n + 2) && (t <= n3 + 2) && (((t - 2) % n) == 0);
        if (e.res_we) e.dr = 4'((t - 2) / n - 1);
        return e;
    endfunction

    // Dir_R only matters on write cycles and while idle/done
    function automatic obs_t masked(input obs_t v, input int n, input int t);
        obs_t r;
        r = v;
        if (!(model(n, t).res_we || t <= 0 || t >= n * n * n + 3)) r.dr = '0;
        return r;
    endfunction

    function automatic obs_t get_obs(input int sel);
        if (sel == 0)
            return {bus2.busy, bus2.done, bus2.Dir_M1, bus2.Dir_M2,
                    bus2.mac_en, bus2.mac_first, bus2.res_we, bus2.Dir_R};
        return {bus4.busy, bus4.done, bus4.Dir_M1, bus4.Dir_M2,
                bus4.mac_en, bus4.mac_first, bus4.res_we, bus4.Dir_R};
    endfunction

    task automatic test_reset();
        obs_t o;
        rst = 1'b0;
        bus2.start = 1'b0;
        bus4.start = 1'b0;
        repeat (3) @(negedge clk);
        for (int sel = 0; sel < 2; sel++) begin
            o = get_obs(sel);
            n_checks++;
            if (o !== '0) begin
                n_errors++;
                $display("FAIL reset_hold sel=%0d observed=%h expected=%h", sel, o, obs_t'('0));
            end
        end
        rst = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            for (int sel = 0; sel < 2; sel++) begin
                o = get_obs(sel);
                n_checks++;
                if (o !== '0) begin
                    n_errors++;
                    $display("FAIL reset_release sel=%0d cycle=%0d observed=%h expected=%h",
                             sel, c, o, obs_t'('0));
                end
            end
        end
    endtask

    task automatic test_n2_run();
        obs_t o, e;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus2.start = 1'b1;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            o = masked(get_obs(0), 2, t);
            e = masked(model(2, t), 2, t);
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL n2_run cycle=%0d observed=%h expected=%h", t, o, e);
            end
        end
    endtask

    task automatic test_n4_run();
        obs_t o, e;
        int   we_cnt;
        int   done_cycle;
        we_cnt     = 0;
        done_cycle = -1;
        @(negedge clk);
        bus4.start = 1'b1;
        @(posedge clk);
        #1 bus4.start = 1'b0;
        for (int t = 1; t <= 70; t++) begin
            @(negedge clk);
            o = get_obs(1);
            if (o.res_we === 1'b1) we_cnt++;
            if (o.done === 1'b1) done_cycle = t;
            o = masked(o, 4, t);
            e = masked(model(4, t), 4, t);
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL n4_run cycle=%0d observed=%h expected=%h", t, o, e);
            end
            bus4.start = (t < 55) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        n_checks++;
        if (we_cnt != 16) begin
            n_errors++;
            $display("FAIL n4_we_count observed=%0d expected=16", we_cnt);
        end
        n_checks++;
        if (done_cycle != 67) begin
            n_errors++;
            $display("FAIL n4_done_cycle observed=%0d expected=67", done_cycle);
        end
    endtask

    task automatic test_reset_midrun();
        obs_t o, e;
        @(negedge clk);
        bus2.start = 1'b1;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            o = masked(get_obs(0), 2, t);
            e = masked(model(2, t), 2, t);
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL midrun_pre cycle=%0d observed=%h expected=%h", t, o, e);
            end
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        o = get_obs(0);
        n_checks++;
        if (o !== '0) begin
            n_errors++;
            $display("FAIL midrun_async observed=%h expected=%h", o, obs_t'('0));
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b1;
            o = get_obs(0);
            n_checks++;
            if (o !== '0) begin
                n_errors++;
                $display("FAIL midrun_quiet step=%0d observed=%h expected=%h", c, o, obs_t'('0));
            end
        end
        bus2.start = 1'b1;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            o = masked(get_obs(0), 2, t);
            e = masked(model(2, t), 2, t);
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL midrun_restart cycle=%0d observed=%h expected=%h", t, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        int   tt;
        @(negedge clk);
        bus2.start = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 26; t++) begin
            @(negedge clk);
            tt = (t <= 12) ? t : t - 12;
            o = masked(get_obs(0), 2, tt);
            e = masked(model(2, tt), 2, tt);
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL back_to_back cycle=%0d observed=%h expected=%h", t, o, e);
            end
            if (t == 13) bus2.start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_n2_run();
        test_n4_run();
        test_reset_midrun();
        test_back_to_back();
        test_n2_run();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
